// File: rtl/rst_sequencer.sv
// Power-on reset sequencer: debounces PLL lock, then releases memory and video resets in order.
// Define RST_SEQ_TIMEOUT_EN to retry memory init on timeout and expose init_timeout_count.
module rst_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int VIDEO_HOLD_CYCLES  = 64,
  parameter int TIMEOUT_CYCLES     = 65536
) (
  input  logic       clk_100Mhz,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       mem_init_done,
  output logic       mem_reset,
  output logic       video_reset,
  output logic       sys_ready,
  output logic [7:0] lock_loss_count,
  output logic [2:0] seq_state
`ifdef RST_SEQ_TIMEOUT_EN
  ,
  output logic [7:0] init_timeout_count
`endif
);

  localparam logic [2:0] WAIT_LOCK   = 3'd0;
  localparam logic [2:0] LOCK_STABLE = 3'd1;
  localparam logic [2:0] MEM_INIT    = 3'd2;
  localparam logic [2:0] VIDEO_HOLD  = 3'd3;
  localparam logic [2:0] RUN         = 3'd4;

  localparam int CNT_MAX_LV = (LOCK_STABLE_CYCLES > VIDEO_HOLD_CYCLES) ? LOCK_STABLE_CYCLES : VIDEO_HOLD_CYCLES;
  localparam int CNT_MAX    = (CNT_MAX_LV > TIMEOUT_CYCLES) ? CNT_MAX_LV : TIMEOUT_CYCLES;
  localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] VIDEO_LAST = CNT_W'(VIDEO_HOLD_CYCLES - 1);
`ifdef RST_SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  // Lock synchroniser; stage 0 samples the asynchronous pll_locked.
  logic [SYNC_STAGES-1:0] sync_reg;
  logic [SYNC_STAGES-1:0] sync_next;
  logic                   locked_s;

  assign sync_next[0] = pll_locked;
  for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
    assign sync_next[gi] = sync_reg[gi-1];
  end

  always_ff @(posedge clk_100Mhz) begin
    if (!reset_n) sync_reg <= '0;
    else          sync_reg <= sync_next;
  end

  assign locked_s = sync_reg[SYNC_STAGES-1];

  logic [2:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             lock_lost;
  logic             mem_reset_reg, video_reset_reg, sys_ready_reg;
  logic [7:0]       lock_loss_reg;
`ifdef RST_SEQ_TIMEOUT_EN
  logic             timeout_hit;
  logic [7:0]       timeout_count_reg;
`endif

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    lock_lost  = 1'b0;
`ifdef RST_SEQ_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    // Lock loss outranks every other transition.
    if (state_reg != WAIT_LOCK && !locked_s) begin
      state_next = WAIT_LOCK;
      cnt_next   = '0;
      lock_lost  = 1'b1;
    end else begin
      case (state_reg)
        WAIT_LOCK: begin
          if (locked_s) begin
            state_next = LOCK_STABLE;
            cnt_next   = '0;
          end
        end
        LOCK_STABLE: begin
          if (cnt_reg == LOCK_LAST) begin
            state_next = MEM_INIT;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        MEM_INIT: begin
          if (mem_init_done) begin
            state_next = VIDEO_HOLD;
            cnt_next   = '0;
          end
`ifdef RST_SEQ_TIMEOUT_EN
          else if (cnt_reg == TIMEOUT_LAST) begin
            state_next  = LOCK_STABLE;
            cnt_next    = '0;
            timeout_hit = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
`endif
        end
        VIDEO_HOLD: begin
          if (cnt_reg == VIDEO_LAST) begin
            state_next = RUN;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        RUN: begin
          state_next = RUN;
        end
        default: begin
          state_next = WAIT_LOCK;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from state_next so they move on the same edge as seq_state.
  always_ff @(posedge clk_100Mhz) begin
    if (!reset_n) begin
      state_reg       <= WAIT_LOCK;
      cnt_reg         <= '0;
      mem_reset_reg   <= 1'b1;
      video_reset_reg <= 1'b1;
      sys_ready_reg   <= 1'b0;
      lock_loss_reg   <= 8'd0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      mem_reset_reg   <= (state_next == WAIT_LOCK) || (state_next == LOCK_STABLE);
      video_reset_reg <= (state_next != RUN);
      sys_ready_reg   <= (state_next == RUN);
      if (lock_lost && lock_loss_reg != 8'hFF)
        lock_loss_reg <= lock_loss_reg + 8'd1;
    end
  end

`ifdef RST_SEQ_TIMEOUT_EN
  always_ff @(posedge clk_100Mhz) begin
    if (!reset_n)
      timeout_count_reg <= 8'd0;
    else if (timeout_hit && timeout_count_reg != 8'hFF)
      timeout_count_reg <= timeout_count_reg + 8'd1;
  end

  assign init_timeout_count = timeout_count_reg;
`endif

  assign mem_reset       = mem_reset_reg;
  assign video_reset     = video_reset_reg;
  assign sys_ready       = sys_ready_reg;
  assign lock_loss_count = lock_loss_reg;
  assign seq_state       = state_reg;

endmodule

// File: tb/tb_rst_sequencer.sv
// Self-checking bench for rst_sequencer: per-edge expected outputs are queued before each
// edge and compared after it.
module tb_rst_sequencer;

  localparam int SYNC_STAGES        = 2;
  localparam int LOCK_STABLE_CYCLES = 8;
  localparam int VIDEO_HOLD_CYCLES  = 4;
  localparam int TIMEOUT_CYCLES     = 16;
  // Edge (counted from the first edge that samples pll_locked=1) after which each state begins.
  localparam int T_LS  = SYNC_STAGES + 1;
  localparam int T_MEM = T_LS + LOCK_STABLE_CYCLES;
  localparam int T_RUN = T_MEM + 1 + VIDEO_HOLD_CYCLES;

  logic       clk_100Mhz    = 1'b0;
  logic       reset_n       = 1'b0;
  logic       pll_locked    = 1'b0;
  logic       mem_init_done = 1'b0;
  logic       mem_reset, video_reset, sys_ready;
  logic [7:0] lock_loss_count;
  logic [2:0] seq_state;
`ifdef RST_SEQ_TIMEOUT_EN
  logic [7:0] init_timeout_count;
`endif

  int errors = 0;
  int checks = 0;
  logic [13:0] exp_q[$];

  always #5 clk_100Mhz = ~clk_100Mhz;

  rst_sequencer #(
    .SYNC_STAGES       (SYNC_STAGES),
    .LOCK_STABLE_CYCLES(LOCK_STABLE_CYCLES),
    .VIDEO_HOLD_CYCLES (VIDEO_HOLD_CYCLES),
    .TIMEOUT_CYCLES    (TIMEOUT_CYCLES)
  ) dut (
    .clk_100Mhz        (clk_100Mhz),
    .reset_n           (reset_n),
    .pll_locked        (pll_locked),
    .mem_init_done     (mem_init_done),
    .mem_reset         (mem_reset),
    .video_reset       (video_reset),
    .sys_ready         (sys_ready),
    .lock_loss_count   (lock_loss_count),
    .seq_state         (seq_state)
`ifdef RST_SEQ_TIMEOUT_EN
    ,
    .init_timeout_count(init_timeout_count)
`endif
  );

  wire [13:0] obs_vec = {seq_state, mem_reset, video_reset, sys_ready, lock_loss_count};

  // Expected {state, mem_reset, video_reset, sys_ready, lock_loss_count}.
  function automatic logic [13:0] exp_vec(input logic [2:0] st, input int llc);
    return {st, (st <= 3'd1), (st != 3'd4), (st == 3'd4), 8'(llc)};
  endfunction

  // State after edge e of an undisturbed sequence with mem_init_done=1.
  function automatic logic [2:0] nominal_state(input int e);
    if (e < T_LS)  return 3'd0;
    if (e < T_MEM) return 3'd1;
    if (e == T_MEM) return 3'd2;
    if (e < T_RUN) return 3'd3;
    return 3'd4;
  endfunction

  task automatic tick();
    @(posedge clk_100Mhz);
    @(negedge clk_100Mhz);
  endtask

  task automatic test_reset();
    logic [13:0] e;
    reset_n = 1'b0; pll_locked = 1'b1; mem_init_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(exp_vec(3'd0, 0));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs_vec !== e) begin
        errors++;
        $display("FAIL reset edge %0d: got %h expected %h", i + 1, obs_vec, e);
      end
    end
  endtask

  task automatic test_sequence();
    logic [13:0] e;
    reset_n = 1'b1;
    for (int k = 1; k <= T_RUN + 4; k++) begin
      exp_q.push_back(exp_vec(nominal_state(k), 0));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs_vec !== e) begin
        errors++;
        $display("FAIL sequence edge %0d: got %h expected %h", k, obs_vec, e);
      end
    end
  endtask

  // Lock dropped for edges 1..5, re-lock first sampled at edge 6.
  task automatic test_lock_loss();
    logic [13:0] e;
    for (int k = 1; k <= 5 + T_RUN; k++) begin
      pll_locked = (k >= 6);
      exp_q.push_back((k <= 2) ? exp_vec(3'd4, 0) : exp_vec(nominal_state(k - 5), 1));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs_vec !== e) begin
        errors++;
        $display("FAIL lock_loss edge %0d: got %h expected %h", k, obs_vec, e);
      end
    end
  endtask

  // One-edge low pulse sampled at edge 7 reaches the FSM at edge 9 while cnt=5.
  task automatic test_glitch();
    logic [13:0] e;
    reset_n = 1'b0; pll_locked = 1'b1; mem_init_done = 1'b1;
    exp_q.push_back(exp_vec(3'd0, 0));
    tick();
    e = exp_q.pop_front();
    checks++;
    if (obs_vec !== e) begin
      errors++;
      $display("FAIL glitch reset clears count: got %h expected %h", obs_vec, e);
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 7 + T_RUN + 1; k++) begin
      pll_locked = (k != 7);
      if (k <= 8)       exp_q.push_back(exp_vec(nominal_state(k), 0));
      else if (k == 9)  exp_q.push_back(exp_vec(3'd0, 1));
      else              exp_q.push_back(exp_vec(nominal_state(k - 7), 1));
      tick();
      e = exp_q.pop_front();
      checks++;
      if (obs_vec !== e) begin
        errors++;
        $display("FAIL glitch edge %0d: got %h expected %h", k, obs_vec, e);
      end
    end
  endtask

  task automatic test_mem_init();
    logic [13:0] e;
    logic [2:0]  st;
    reset_n = 1'b0; pll_locked = 1'b1; mem_init_done = 1'b0;
    exp_q.push_back(exp_vec(3'd0, 0));
    tick();
    e = exp_q.pop_front();
    checks++;
    if (obs_vec !== e) begin
      errors++;
      $display("FAIL mem_init reset: got %h expected %h", obs_vec, e);
    end
    reset_n = 1'b1;
`ifdef RST_SEQ_TIMEOUT_EN
    begin
      int to_edge, retry_edge;
      logic [7:0] exp_to;
      to_edge    = T_MEM + TIMEOUT_CYCLES;
      retry_edge = to_edge + LOCK_STABLE_CYCLES;
      for (int k = 1; k <= retry_edge + 1 + VIDEO_HOLD_CYCLES; k++) begin
        mem_init_done = (k > retry_edge);
        if (k < T_MEM)                              st = nominal_state(k);
        else if (k < to_edge)                       st = 3'd2;
        else if (k < retry_edge)                    st = 3'd1;
        else if (k == retry_edge)                   st = 3'd2;
        else if (k < retry_edge + 1 + VIDEO_HOLD_CYCLES) st = 3'd3;
        else                                        st = 3'd4;
        exp_q.push_back(exp_vec(st, 0));
        exp_to = (k >= to_edge) ? 8'd1 : 8'd0;
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs_vec !== e) begin
          errors++;
          $display("FAIL timeout edge %0d: got %h expected %h", k, obs_vec, e);
        end
        checks++;
        if (init_timeout_count !== exp_to) begin
          errors++;
          $display("FAIL init_timeout_count edge %0d: got %0d expected %0d", k, init_timeout_count, exp_to);
        end
      end
    end
`else
    begin
      int hold_end;
      hold_end = T_MEM + 1000;
      for (int k = 1; k <= hold_end + 1 + VIDEO_HOLD_CYCLES; k++) begin
        mem_init_done = (k > hold_end);
        if (k < T_MEM)                             st = nominal_state(k);
        else if (k <= hold_end)                    st = 3'd2;
        else if (k < hold_end + 1 + VIDEO_HOLD_CYCLES) st = 3'd3;
        else                                       st = 3'd4;
        exp_q.push_back(exp_vec(st, 0));
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs_vec !== e) begin
          errors++;
          $display("FAIL mem_wait edge %0d: got %h expected %h", k, obs_vec, e);
        end
      end
    end
`endif
  endtask

  // Each 5-edge period (locked 3 samples, unlocked 2) produces exactly one lock loss.
  task automatic test_saturation();
    logic [13:0] e;
    reset_n = 1'b0; pll_locked = 1'b0; mem_init_done = 1'b1;
    exp_q.push_back(exp_vec(3'd0, 0));
    tick();
    e = exp_q.pop_front();
    checks++;
    if (obs_vec !== e) begin
      errors++;
      $display("FAIL saturation reset: got %h expected %h", obs_vec, e);
    end
    reset_n = 1'b1;
    for (int q = 0; q <= 300; q++) begin
      exp_q.push_back(exp_vec(3'd1, (q > 255) ? 255 : q));
      for (int j = 1; j <= 5; j++) begin
        pll_locked = (j <= 3);
        tick();
      end
      e = exp_q.pop_front();
      checks++;
      if (obs_vec !== e) begin
        errors++;
        $display("FAIL saturation period %0d: got %h expected %h", q, obs_vec, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_lock_loss();
    test_glitch();
    test_mem_init();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
